// File: rtl/xdrop_extender.sv
// X-drop ungapped extension scorer: accumulates a saturating signed score over
// comparator beats, tracks the best score and its length, and reports why it stopped.
module xdrop_extender #(
  parameter int MATCH_SCORE  = 1,
  parameter int MISMATCH_PEN = 3,
  parameter int GAP_PEN      = 5,
  parameter int X_DROP       = 10,
  parameter int THRESHOLD    = 4,
  parameter int SCORE_W      = 16,
  parameter int LEN_W        = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_in_valid,
  input  logic [2:0]                i_result,
  input  logic                      i_last,
  output logic                      o_in_ready,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [SCORE_W-1:0] o_best_score,
  output logic [LEN_W-1:0]          o_best_len,
  output logic [1:0]                o_term,
  output logic                      o_hit,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXTEND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic signed [SCORE_W:0]   P_D_MATCH = (SCORE_W+1)'(MATCH_SCORE);
  localparam logic signed [SCORE_W:0]   P_D_MIS   = (SCORE_W+1)'(-MISMATCH_PEN);
  localparam logic signed [SCORE_W:0]   P_D_GAP   = (SCORE_W+1)'(-GAP_PEN);
  localparam logic signed [SCORE_W-1:0] P_SMAX    = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] P_SMIN    = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] P_THRESH  = SCORE_W'(THRESHOLD);
  localparam logic signed [31:0]        P_XDROP   = X_DROP;
  localparam logic [LEN_W-1:0]          P_LEN_FULL = {LEN_W{1'b1}};

  localparam logic [1:0] TERM_NONE  = 2'b00;
  localparam logic [1:0] TERM_XDROP = 2'b01;
  localparam logic [1:0] TERM_LAST  = 2'b10;
  localparam logic [1:0] TERM_FULL  = 2'b11;

  // Unrecognised comparator codes are scored as gaps.
  function automatic logic signed [SCORE_W:0] delta_f(input logic [2:0] code);
    case (code)
      3'b100:  delta_f = P_D_MATCH;
      3'b010:  delta_f = P_D_MIS;
      default: delta_f = P_D_GAP;
    endcase
  endfunction

  state_t                      r_state, w_state_nxt;
  logic signed [SCORE_W-1:0]   r_score, w_score_nxt;
  logic signed [SCORE_W-1:0]   r_best, w_best_nxt;
  logic [LEN_W-1:0]            r_len, w_len_nxt;
  logic [LEN_W-1:0]            r_best_len, w_best_len_nxt;
  logic [1:0]                  r_term, w_term_nxt;

  logic signed [SCORE_W:0]     w_sum;
  logic signed [SCORE_W-1:0]   w_score_n;
  logic signed [SCORE_W-1:0]   w_best_upd;
  logic                        w_best_gt;
  logic [LEN_W-1:0]            w_len_n;
  logic signed [31:0]          w_drop;

  // Candidate score/length for the beat on the input, with saturation on overflow.
  always_comb begin
    w_sum = {r_score[SCORE_W-1], r_score} + delta_f(i_result);
    if (w_sum[SCORE_W] != w_sum[SCORE_W-1]) begin
      if (w_sum[SCORE_W]) begin
        w_score_n = P_SMIN;
      end else begin
        w_score_n = P_SMAX;
      end
    end else begin
      w_score_n = w_sum[SCORE_W-1:0];
    end
    w_best_gt = (w_score_n > r_best);
    if (w_best_gt) begin
      w_best_upd = w_score_n;
    end else begin
      w_best_upd = r_best;
    end
    // Drop is evaluated against the best score including this beat's update.
    w_drop  = {{(32-SCORE_W){w_best_upd[SCORE_W-1]}}, w_best_upd}
            - {{(32-SCORE_W){w_score_n[SCORE_W-1]}}, w_score_n};
    w_len_n = r_len + {{(LEN_W-1){1'b0}}, 1'b1};
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_score_nxt    = r_score;
    w_best_nxt     = r_best;
    w_len_nxt      = r_len;
    w_best_len_nxt = r_best_len;
    w_term_nxt     = r_term;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_score_nxt    = '0;
          w_best_nxt     = '0;
          w_len_nxt      = '0;
          w_best_len_nxt = '0;
          w_term_nxt     = TERM_NONE;
          w_state_nxt    = ST_EXTEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXTEND: begin
        if (i_in_valid) begin
          w_score_nxt = w_score_n;
          w_len_nxt   = w_len_n;
          if (w_best_gt) begin
            w_best_nxt     = w_score_n;
            w_best_len_nxt = w_len_n;
          end else begin
            w_best_nxt     = r_best;
            w_best_len_nxt = r_best_len;
          end
          if (w_drop > P_XDROP) begin
            w_term_nxt  = TERM_XDROP;
            w_state_nxt = ST_DONE;
          end else if (i_last) begin
            w_term_nxt  = TERM_LAST;
            w_state_nxt = ST_DONE;
          end else if (w_len_n == P_LEN_FULL) begin
            w_term_nxt  = TERM_FULL;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_EXTEND;
          end
        end else begin
          w_state_nxt = ST_EXTEND;
        end
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_score    <= '0;
      r_best     <= '0;
      r_len      <= '0;
      r_best_len <= '0;
      r_term     <= TERM_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_score    <= w_score_nxt;
      r_best     <= w_best_nxt;
      r_len      <= w_len_nxt;
      r_best_len <= w_best_len_nxt;
      r_term     <= w_term_nxt;
    end
  end

  assign o_in_ready   = (r_state == ST_EXTEND);
  assign o_out_valid  = (r_state == ST_DONE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_best_score = r_best;
  assign o_best_len   = r_best_len;
  assign o_term       = r_term;
  assign o_hit        = (r_best >= P_THRESH);

endmodule

// File: tb/tb_xdrop_extender.sv
// Bench for xdrop_extender: scenario tasks push expected results to a scoreboard
// that a negedge monitor pops and compares whenever out_valid appears.
module tb_xdrop_extender;

  localparam logic [2:0] M = 3'b100;
  localparam logic [2:0] X = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk = 1'b0;
  logic rst, start, in_valid, last, out_ready;
  logic [2:0] result;

  logic d0_ir, d0_ov, d0_hit, d0_busy;
  logic signed [15:0] d0_score;
  logic [15:0] d0_len;
  logic [1:0]  d0_term;
  logic d1_ir, d1_ov, d1_hit, d1_busy;
  logic signed [15:0] d1_score;
  logic [3:0]  d1_len;
  logic [1:0]  d1_term;
  logic d2_ir, d2_ov, d2_hit, d2_busy;
  logic signed [3:0] d2_score;
  logic [15:0] d2_len;
  logic [1:0]  d2_term;

  int sel = 0;
  logic obs_ir, obs_ov, obs_hit, obs_busy;
  logic signed [15:0] obs_score;
  logic [15:0] obs_len;
  logic [1:0]  obs_term;

  typedef struct {
    string name;
    logic signed [15:0] score;
    logic [15:0] len;
    logic [1:0] term;
    logic hit;
    int beats;
  } exp_t;

  exp_t sb_q[$];
  logic [2:0] beat_q[$];
  int acc_cnt = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  xdrop_extender u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .i_result(result),
    .i_last(last), .o_in_ready(d0_ir), .o_out_valid(d0_ov), .i_out_ready(out_ready),
    .o_best_score(d0_score), .o_best_len(d0_len), .o_term(d0_term), .o_hit(d0_hit), .o_busy(d0_busy));

  xdrop_extender #(.LEN_W(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .i_result(result),
    .i_last(last), .o_in_ready(d1_ir), .o_out_valid(d1_ov), .i_out_ready(out_ready),
    .o_best_score(d1_score), .o_best_len(d1_len), .o_term(d1_term), .o_hit(d1_hit), .o_busy(d1_busy));

  xdrop_extender #(.SCORE_W(4), .X_DROP(7)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .i_result(result),
    .i_last(last), .o_in_ready(d2_ir), .o_out_valid(d2_ov), .i_out_ready(out_ready),
    .o_best_score(d2_score), .o_best_len(d2_len), .o_term(d2_term), .o_hit(d2_hit), .o_busy(d2_busy));

  always_comb begin
    case (sel)
      1: begin
        obs_ir = d1_ir; obs_ov = d1_ov; obs_hit = d1_hit; obs_busy = d1_busy;
        obs_score = d1_score; obs_len = {12'd0, d1_len}; obs_term = d1_term;
      end
      2: begin
        obs_ir = d2_ir; obs_ov = d2_ov; obs_hit = d2_hit; obs_busy = d2_busy;
        obs_score = {{12{d2_score[3]}}, d2_score}; obs_len = d2_len; obs_term = d2_term;
      end
      default: begin
        obs_ir = d0_ir; obs_ov = d0_ov; obs_hit = d0_hit; obs_busy = d0_busy;
        obs_score = d0_score; obs_len = d0_len; obs_term = d0_term;
      end
    endcase
  end

  // Scoreboard consumer: one pop per out_valid episode.
  initial begin
    bit seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (obs_ov && !seen) begin
        seen = 1'b1;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result score=%0d len=%0d term=%b", obs_score, obs_len, obs_term);
        end else begin
          e = sb_q.pop_front();
          if (obs_score !== e.score) begin
            bad++; $display("FAIL %s.best_score got=%0d want=%0d", e.name, obs_score, e.score);
          end
          total++;
          if (obs_len !== e.len) begin
            bad++; $display("FAIL %s.best_len got=%0d want=%0d", e.name, obs_len, e.len);
          end
          total++;
          if (obs_term !== e.term) begin
            bad++; $display("FAIL %s.term got=%b want=%b", e.name, obs_term, e.term);
          end
          total++;
          if (obs_hit !== e.hit) begin
            bad++; $display("FAIL %s.hit got=%b want=%b", e.name, obs_hit, e.hit);
          end
          total++;
          if (acc_cnt !== e.beats) begin
            bad++; $display("FAIL %s.beats got=%0d want=%0d", e.name, acc_cnt, e.beats);
          end
        end
      end else if (!obs_ov) begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string name, input int score, input int len,
                          input logic [1:0] term, input logic hit, input int beats);
    exp_t e;
    e.name = name; e.score = 16'(score); e.len = 16'(len);
    e.term = term; e.hit = hit; e.beats = beats;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0; result = 3'b000; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Pulses start, then streams beat_q back to back until out_valid appears.
  task automatic drive_seq(input bit use_last, input int start_at);
    int n;
    n = beat_q.size();
    acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      result = beat_q[i];
      last = use_last && (i == n - 1);
      start = (i == start_at);
      if (obs_ir) acc_cnt++;
      @(posedge clk); #1;
      start = 1'b0;
      if (obs_ov) break;
    end
    in_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s.timeout got=%0d pending want=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; result = M; last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (obs_ov !== 1'b0) begin bad++; $display("FAIL reset.out_valid got=%b want=0", obs_ov); end
    total++; if (obs_ir !== 1'b0) begin bad++; $display("FAIL reset.in_ready got=%b want=0", obs_ir); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset.busy got=%b want=0", obs_busy); end
    total++; if (obs_score !== 16'sd0) begin bad++; $display("FAIL reset.best_score got=%0d want=0", obs_score); end
    total++; if (obs_len !== 16'd0) begin bad++; $display("FAIL reset.best_len got=%0d want=0", obs_len); end
    total++; if (obs_term !== 2'b00) begin bad++; $display("FAIL reset.term got=%b want=00", obs_term); end
    total++; if (obs_hit !== 1'b0) begin bad++; $display("FAIL reset.hit got=%b want=0", obs_hit); end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_all_match();
    do_reset(); sel = 0;
    beat_q = '{M, M, M, M, M};
    push_exp("all_match", 5, 5, 2'b10, 1'b1, 5);
    drive_seq(1'b1, -1);
    wait_drain("all_match");
  endtask

  task automatic test_xdrop();
    do_reset(); sel = 0;
    beat_q = '{M, M, M, X, X, X, X, X, X, X, X, X, X};
    push_exp("xdrop", 3, 3, 2'b01, 1'b0, 7);
    drive_seq(1'b0, -1);
    wait_drain("xdrop");
  endtask

  task automatic test_gap_recover();
    do_reset(); sel = 0;
    beat_q = '{M, M, G, M, M, M, M, M, M};
    push_exp("gap_recover", 3, 9, 2'b10, 1'b0, 9);
    drive_seq(1'b1, 4);
    wait_drain("gap_recover");
  endtask

  task automatic test_tie();
    do_reset(); sel = 0;
    beat_q = '{M, M, M, X, M, M, M};
    push_exp("tie", 3, 3, 2'b10, 1'b0, 7);
    drive_seq(1'b1, -1);
    wait_drain("tie");
  endtask

  task automatic test_all_mismatch();
    do_reset(); sel = 0;
    beat_q = '{X, X, X, X, X, X, X, X};
    push_exp("all_mismatch", 0, 0, 2'b01, 1'b0, 4);
    drive_seq(1'b0, -1);
    wait_drain("all_mismatch");
  endtask

  task automatic test_other_codes();
    do_reset(); sel = 0;
    beat_q = '{M, M, 3'b000, 3'b111, 3'b011, G, G};
    push_exp("other_codes", 2, 2, 2'b01, 1'b0, 5);
    drive_seq(1'b0, -1);
    wait_drain("other_codes");
  endtask

  task automatic test_hold();
    do_reset(); sel = 0;
    out_ready = 1'b0;
    beat_q = '{M, M, M, M, M};
    push_exp("hold", 5, 5, 2'b10, 1'b1, 5);
    drive_seq(1'b1, -1);
    for (int c = 0; c < 3; c++) begin
      start = 1'b1;
      @(posedge clk); #1;
      total++; if (obs_ov !== 1'b1) begin bad++; $display("FAIL hold.out_valid cyc=%0d got=%b want=1", c, obs_ov); end
      total++; if (obs_ir !== 1'b0) begin bad++; $display("FAIL hold.in_ready cyc=%0d got=%b want=0", c, obs_ir); end
      total++; if (obs_score !== 16'sd5) begin bad++; $display("FAIL hold.best_score cyc=%0d got=%0d want=5", c, obs_score); end
      total++; if (obs_len !== 16'd5) begin bad++; $display("FAIL hold.best_len cyc=%0d got=%0d want=5", c, obs_len); end
      total++; if (obs_term !== 2'b10) begin bad++; $display("FAIL hold.term cyc=%0d got=%b want=10", c, obs_term); end
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (obs_ov !== 1'b0) begin bad++; $display("FAIL hold.release_valid got=%b want=0", obs_ov); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL hold.release_busy got=%b want=0", obs_busy); end
    @(posedge clk); #1;
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL hold.start_ignored got=%b want=0", obs_busy); end
    wait_drain("hold");
  endtask

  task automatic test_reset_mid();
    do_reset(); sel = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; result = M;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_mid.busy got=%b want=0", obs_busy); end
    total++; if (obs_ir !== 1'b0) begin bad++; $display("FAIL reset_mid.in_ready got=%b want=0", obs_ir); end
    total++; if (obs_score !== 16'sd0) begin bad++; $display("FAIL reset_mid.best_score got=%0d want=0", obs_score); end
    total++; if (obs_len !== 16'd0) begin bad++; $display("FAIL reset_mid.best_len got=%0d want=0", obs_len); end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    beat_q = '{M, M, M, M};
    push_exp("reset_mid_fresh", 4, 4, 2'b10, 1'b1, 4);
    drive_seq(1'b1, -1);
    wait_drain("reset_mid_fresh");
  endtask

  task automatic test_len_full();
    do_reset(); sel = 1;
    beat_q.delete();
    for (int i = 0; i < 18; i++) beat_q.push_back(M);
    push_exp("len_full", 15, 15, 2'b11, 1'b1, 15);
    drive_seq(1'b0, -1);
    wait_drain("len_full");
  endtask

  task automatic test_saturate();
    do_reset(); sel = 2;
    beat_q = '{G, G, G, G};
    push_exp("saturate", 0, 0, 2'b01, 1'b0, 2);
    drive_seq(1'b0, -1);
    wait_drain("saturate");
  endtask

  task automatic test_back_to_back();
    do_reset(); sel = 0;
    beat_q = '{M, M, M};
    push_exp("b2b_first", 3, 3, 2'b10, 1'b0, 3);
    drive_seq(1'b1, -1);
    wait_drain("b2b_first");
    beat_q = '{M, X, M, M};
    push_exp("b2b_second", 1, 1, 2'b10, 1'b0, 4);
    drive_seq(1'b1, -1);
    wait_drain("b2b_second");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0; result = 3'b000; out_ready = 1'b1;
    test_reset();
    test_all_match();
    test_xdrop();
    test_gap_recover();
    test_tie();
    test_all_mismatch();
    test_other_codes();
    test_hold();
    test_reset_mid();
    test_len_full();
    test_saturate();
    test_back_to_back();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
